// File: rtl/level_sensor_reader.sv
// Tank level probe reader: synchronizes and debounces the h/m/l probes, checks the
// accepted pattern for consistency and latches a fault after repeated illegal samples.
module level_sensor_reader #(
    parameter int unsigned DEB_N   = 4,
    parameter int unsigned FAULT_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       h,
    input  logic       m,
    input  logic       l,
    input  logic       clr_err,
    output logic       h_s,
    output logic       m_s,
    output logic       l_s,
    output logic [1:0] level,
    output logic       err,
    output logic       upd
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned PROBES   = 3;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_N - 1);
    localparam logic [CNT_W-1:0] FAULT_LIM = CNT_W'(FAULT_N);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    logic [PROBES-1:0] sync_q1;
    logic [PROBES-1:0] sync_q2;
    logic [PROBES-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q [PROBES];
    logic              tick_q;

    state_t            state_q;
    state_t            state_nx;
    logic [CNT_W-1:0]  fcnt_q;
    logic [CNT_W-1:0]  fcnt_nx;
    logic [PROBES-1:0] probes_nx;
    logic [1:0]        level_nx;
    logic              err_nx;
    logic [1:0]        level_d;
    logic              err_d;
    logic              legal;

    function automatic logic [1:0] encode(input logic [2:0] p);
        logic [1:0] e;
        case (p)
            3'b001:  e = 2'b01;
            3'b011:  e = 2'b10;
            3'b111:  e = 2'b11;
            default: e = 2'b00;
        endcase
        return e;
    endfunction

    // Two-flop synchronizer for the asynchronous probes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {h, m, l};
            sync_q2 <= sync_q1;
        end
    end

    // Per-probe debounce; counter clears both on a matching sample and on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            for (int i = 0; i < PROBES; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < PROBES; i++) begin
                if (sync_q2[i] != acc_q[i]) begin
                    if (cnt_q[i] == DEB_LAST) begin
                        acc_q[i] <= sync_q2[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // The fault FSM evaluates one clk after the tick so it sees the combined new triple
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign legal = (acc_q == 3'b000) || (acc_q == 3'b001) ||
                   (acc_q == 3'b011) || (acc_q == 3'b111);

    always_comb begin
        state_nx  = state_q;
        fcnt_nx   = fcnt_q;
        probes_nx = {h_s, m_s, l_s};
        level_nx  = level;
        err_nx    = err;
        case (state_q)
            ST_OK: begin
                if (tick_q) begin
                    if (legal) begin
                        probes_nx = acc_q;
                        level_nx  = encode(acc_q);
                    end else if (CNT_W'(1) >= FAULT_LIM) begin
                        state_nx = ST_FAULT;
                        fcnt_nx  = '0;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = ST_SUSPECT;
                        fcnt_nx  = CNT_W'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                if (tick_q) begin
                    if (legal) begin
                        state_nx  = ST_OK;
                        fcnt_nx   = '0;
                        probes_nx = acc_q;
                        level_nx  = encode(acc_q);
                    end else if (fcnt_q + CNT_W'(1) >= FAULT_LIM) begin
                        state_nx = ST_FAULT;
                        fcnt_nx  = '0;
                        err_nx   = 1'b1;
                    end else begin
                        fcnt_nx = fcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                err_nx = 1'b1;
                if (clr_err) begin
                    state_nx = ST_OK;
                    err_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = ST_OK;
                fcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OK;
            fcnt_q  <= '0;
            h_s     <= 1'b0;
            m_s     <= 1'b0;
            l_s     <= 1'b0;
            level   <= 2'b00;
            err     <= 1'b0;
        end else begin
            state_q           <= state_nx;
            fcnt_q            <= fcnt_nx;
            {h_s, m_s, l_s}   <= probes_nx;
            level             <= level_nx;
            err               <= err_nx;
        end
    end

    // Update pulse follows the edge on which level or err changed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 2'b00;
            err_d   <= 1'b0;
            upd     <= 1'b0;
        end else begin
            level_d <= level;
            err_d   <= err;
            upd     <= (level != level_d) || (err != err_d);
        end
    end

endmodule

// File: tb/tb_level_sensor_reader.sv
// Scoreboard bench for level_sensor_reader: expected update payloads are queued as
// stimulus is applied and compared whenever the DUT pulses upd.
module tb_level_sensor_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       h, m, l;
    logic       clr_err;
    logic       h_s, m_s, l_s;
    logic [1:0] level;
    logic       err;
    logic       upd;

    int         checks  = 0;
    int         errors  = 0;
    int         upd_cnt = 0;
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    level_sensor_reader #(.DEB_N(4), .FAULT_N(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .h       (h),
        .m       (m),
        .l       (l),
        .clr_err (clr_err),
        .h_s     (h_s),
        .m_s     (m_s),
        .l_s     (l_s),
        .level   (level),
        .err     (err),
        .upd     (upd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] word(input logic [1:0] lv, input logic e, input logic [2:0] p);
        return {lv, e, p};
    endfunction

    task automatic set_probes(input logic [2:0] v);
        {h, m, l} = v;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: every upd pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && upd) begin
            upd_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_upd", {26'd0, level, err, h_s, m_s, l_s}, 32'hFFFF_FFFF);
            end else begin
                check("upd_payload", {26'd0, level, err, h_s, m_s, l_s}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; clr_err = 1'b0; {h, m, l} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word", {level, err, h_s, m_s, l_s}, 0);
        check("rst_upd", upd, 0);
        rst = 1'b0;

        // Clean rise of l
        set_probes(3'b001);
        ticks(3);
        check("s1_pre_level", level, 0);
        exp_q.push_back(word(2'b01, 1'b0, 3'b001));
        ticks(1);
        check("s1_level", level, 1);
        check("s1_l_s", l_s, 1);
        check("s1_upd_cnt", upd_cnt, 1);

        exp_q.push_back(word(2'b00, 1'b0, 3'b000));
        set_probes(3'b000);
        ticks(4);
        check("s1b_level", level, 0);
        check("s1b_upd_cnt", upd_cnt, 2);

        // Three-tick glitch must not be accepted
        set_probes(3'b001);
        ticks(3);
        set_probes(3'b000);
        ticks(5);
        check("s2_level", level, 0);
        check("s2_l_s", l_s, 0);
        check("s2_upd_cnt", upd_cnt, 2);

        // m and l together go straight to medium
        set_probes(3'b011);
        ticks(3);
        check("s3_pre_level", level, 0);
        exp_q.push_back(word(2'b10, 1'b0, 3'b011));
        ticks(1);
        check("s3_level", level, 2);
        check("s3_err", err, 0);
        check("s3_upd_cnt", upd_cnt, 3);

        // clr_err outside FAULT has no effect
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        ticks(1);
        check("s3_clr_err", err, 0);
        check("s3_clr_upd_cnt", upd_cnt, 3);

        exp_q.push_back(word(2'b00, 1'b0, 3'b000));
        set_probes(3'b000);
        ticks(4);
        check("s4_empty", level, 0);

        // Illegal 101: two suspect ticks, fault on the third
        set_probes(3'b101);
        ticks(5);
        check("s4_suspect_err", err, 0);
        check("s4_suspect_level", level, 0);
        exp_q.push_back(word(2'b00, 1'b1, 3'b000));
        ticks(1);
        check("s4_fault_err", err, 1);
        check("s4_upd_cnt", upd_cnt, 5);
        ticks(3);
        check("s4_frozen_level", level, 0);
        check("s4_frozen_h_s", h_s, 0);
        check("s4_frozen_upd_cnt", upd_cnt, 5);

        // Clear fault with probes at 011
        set_probes(3'b011);
        ticks(4);
        check("s5_still_fault", err, 1);
        check("s5_still_level", level, 0);
        exp_q.push_back(word(2'b00, 1'b0, 3'b000));
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("s5_err_cleared", err, 0);
        check("s5_level_held", level, 0);
        repeat (2) @(posedge clk);
        #1;
        check("s5_clr_upd_cnt", upd_cnt, 6);
        exp_q.push_back(word(2'b10, 1'b0, 3'b011));
        ticks(1);
        check("s5_level", level, 2);
        check("s5_m_s", m_s, 1);
        check("s5_upd_cnt", upd_cnt, 7);

        // Fault at level high, then reset
        exp_q.push_back(word(2'b11, 1'b0, 3'b111));
        set_probes(3'b111);
        ticks(4);
        check("s6_high", level, 3);
        exp_q.push_back(word(2'b11, 1'b1, 3'b111));
        set_probes(3'b101);
        ticks(6);
        check("s6_fault", err, 1);
        check("s6_level", level, 3);
        check("s6_upd_cnt", upd_cnt, 9);
        #2 rst = 1'b1;
        #1;
        check("s6_rst_word", {level, err, h_s, m_s, l_s}, 0);
        check("s6_rst_upd", upd, 0);
        set_probes(3'b000);
        rst = 1'b0;
        ticks(3);
        check("s6_post_level", level, 0);
        check("s6_post_upd_cnt", upd_cnt, 9);
        check("pending_exp", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
